// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller for the 5-stage core: merges stall requests,
// redirects and interrupt entry into one registered hold level. Optional MEM-stall watchdog: PIPE_HOLD_WDT_EN.
module pipe_hold_ctrl #(
  parameter int FLUSH_CYCLES = 2
`ifdef PIPE_HOLD_WDT_EN
  , parameter int WDT_LIMIT = 255
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_hold_req_i,
  input  logic        ex_hold_req_i,
  input  logic        mem_hold_req_i,
  input  logic        jump_req_i,
  input  logic [31:0] jump_addr_i,
  input  logic        int_req_i,
  input  logic [31:0] int_addr_i,
  output logic [2:0]  hold_flag_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic        int_ack_o,
  output logic        wdt_timeout_o,
  output logic [1:0]  fsm_state_o
);

  // Requests are levels: jump_req_i and int_req_i stay asserted until accepted
  // (jump_o / int_ack_o strobe one cycle); nothing is accepted while EX or MEM stalls.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [2:0] HOLD_NONE  = 3'd0;
  localparam logic [2:0] HOLD_IF    = 3'd2;
  localparam logic [2:0] HOLD_ID    = 3'd3;
  localparam logic [2:0] HOLD_EX    = 3'd4;
  localparam logic [2:0] HOLD_MEM   = 3'd5;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  req_lvl;
  logic        lvl_low;
  logic        jump_take;
  logic        int_take;
  logic [2:0]  hold_d;
  logic        jump_d;
  logic [31:0] jump_addr_d;
  logic        int_ack_d;
  logic        wdt_fire;

  always_comb begin
    if (mem_hold_req_i)     req_lvl = HOLD_MEM;
    else if (ex_hold_req_i) req_lvl = HOLD_EX;
    else if (id_hold_req_i) req_lvl = HOLD_ID;
    else                    req_lvl = HOLD_NONE;
  end

  assign lvl_low   = (req_lvl < HOLD_EX);
  assign jump_take = jump_req_i && lvl_low;
  assign int_take  = int_req_i && lvl_low;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      cnt_q         <= 3'd0;
      hold_flag_o   <= HOLD_NONE;
      jump_o        <= 1'b0;
      jump_addr_o   <= 32'd0;
      int_ack_o     <= 1'b0;
      wdt_timeout_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_flag_o   <= wdt_fire ? HOLD_NONE : hold_d;
      jump_o        <= jump_d;
      jump_addr_o   <= jump_addr_d;
      int_ack_o     <= int_ack_d;
      wdt_timeout_o <= wdt_fire;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (jump_take) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_INIT;
        end else if (int_req_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_FLUSH: begin
        // The flush window freezes while an older instruction stalls EX/MEM.
        if (lvl_low) begin
          if (cnt_q == 3'd0) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 3'd1;
        end
      end
      ST_DRAIN: begin
        if (jump_take || int_take) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_INIT;
        end else if (!int_req_i) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    hold_d      = req_lvl;
    jump_d      = 1'b0;
    jump_addr_d = jump_addr_o;
    int_ack_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (jump_take) begin
          jump_d      = 1'b1;
          jump_addr_d = jump_addr_i;
        end
      end
      ST_FLUSH: begin
        hold_d = (req_lvl > HOLD_ID) ? req_lvl : HOLD_ID;
      end
      ST_DRAIN: begin
        hold_d = (req_lvl > HOLD_IF) ? req_lvl : HOLD_IF;
        if (jump_take) begin
          jump_d      = 1'b1;
          jump_addr_d = jump_addr_i;
        end else if (int_take) begin
          int_ack_d   = 1'b1;
          jump_d      = 1'b1;
          jump_addr_d = int_addr_i;
        end
      end
      default: ;
    endcase
  end

`ifdef PIPE_HOLD_WDT_EN
  logic [15:0] wdt_cnt_q;

  assign wdt_fire = mem_hold_req_i && (wdt_cnt_q == 16'(WDT_LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           wdt_cnt_q <= 16'd0;
    else if (!mem_hold_req_i || wdt_fire) wdt_cnt_q <= 16'd0;
    else                                wdt_cnt_q <= wdt_cnt_q + 16'd1;
  end
`else
  assign wdt_fire = 1'b0;
`endif

  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Randomized bench for pipe_hold_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural model through an expected queue.
module tb_pipe_hold_ctrl;

  localparam int FC  = 2;
  localparam int WDL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_hold_req_i = 1'b0, ex_hold_req_i = 1'b0, mem_hold_req_i = 1'b0;
  logic        jump_req_i = 1'b0, int_req_i = 1'b0;
  logic [31:0] jump_addr_i = 32'd0, int_addr_i = 32'd0;
  logic [2:0]  hold_flag_o;
  logic        jump_o, int_ack_o, wdt_timeout_o;
  logic [31:0] jump_addr_o;
  logic [1:0]  fsm_state_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [37:0] exp_q[$];

  pipe_hold_ctrl #(
    .FLUSH_CYCLES(FC)
`ifdef PIPE_HOLD_WDT_EN
    , .WDT_LIMIT(WDL)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .id_hold_req_i(id_hold_req_i), .ex_hold_req_i(ex_hold_req_i),
    .mem_hold_req_i(mem_hold_req_i), .jump_req_i(jump_req_i),
    .jump_addr_i(jump_addr_i), .int_req_i(int_req_i), .int_addr_i(int_addr_i),
    .hold_flag_o(hold_flag_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o),
    .int_ack_o(int_ack_o), .wdt_timeout_o(wdt_timeout_o), .fsm_state_o(fsm_state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  // ---------------- behavioural model ----------------
  // phase: 0 = normal flow, 1 = flushing after a redirect, 2 = waiting to take an interrupt
  int          phase;
  int          flush_left;
  int          stall_run;
  logic [2:0]  m_hold;
  logic        m_jump, m_ack, m_wdt;
  logic [31:0] m_addr;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    phase = 0; flush_left = 0; stall_run = 0;
    m_hold = 3'd0; m_jump = 1'b0; m_ack = 1'b0; m_wdt = 1'b0; m_addr = 32'd0;
  endtask

  task automatic model_step();
    int lvl;
    int hold;
    lvl = mem_hold_req_i ? 5 : ex_hold_req_i ? 4 : id_hold_req_i ? 3 : 0;
    m_jump = 1'b0; m_ack = 1'b0; m_wdt = 1'b0;
    hold = lvl;
    if (phase == 0) begin
      if (jump_req_i && lvl < 4) begin
        m_jump = 1'b1; m_addr = jump_addr_i; flush_left = FC; phase = 1;
      end else if (int_req_i) phase = 2;
    end else if (phase == 1) begin
      hold = max2(3, lvl);
      if (lvl < 4) begin
        flush_left--;
        if (flush_left == 0) phase = 0;
      end
    end else begin
      hold = max2(2, lvl);
      if (jump_req_i && lvl < 4) begin
        m_jump = 1'b1; m_addr = jump_addr_i; flush_left = FC; phase = 1;
      end else if (!int_req_i) phase = 0;
      else if (lvl < 4) begin
        m_ack = 1'b1; m_jump = 1'b1; m_addr = int_addr_i; flush_left = FC; phase = 1;
      end
    end
`ifdef PIPE_HOLD_WDT_EN
    if (mem_hold_req_i) begin
      stall_run++;
      if (stall_run == WDL) begin
        m_wdt = 1'b1; stall_run = 0; hold = 0;
      end
    end else stall_run = 0;
`endif
    m_hold = 3'(hold);
    exp_q.push_back({m_hold, m_jump, m_addr, m_ack, m_wdt});
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hold"}, 32'(hold_flag_o), 32'd0);
    check({tag, "_jump"}, 32'(jump_o), 32'd0);
    check({tag, "_addr"}, jump_addr_o, 32'd0);
    check({tag, "_ack"},  32'(int_ack_o), 32'd0);
    check({tag, "_wdt"},  32'(wdt_timeout_o), 32'd0);
    check({tag, "_fsm"},  32'(fsm_state_o), 32'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic id, input logic ex, input logic mem, input logic jmp,
                       input logic [31:0] ja, input logic intr, input logic [31:0] ia);
    id_hold_req_i = id; ex_hold_req_i = ex; mem_hold_req_i = mem;
    jump_req_i = jmp; jump_addr_i = ja; int_req_i = intr; int_addr_i = ia;
  endtask

  task automatic rand_drive();
    id_hold_req_i  = ($urandom_range(0, 9) < 2);
    ex_hold_req_i  = ($urandom_range(0, 9) < 2);
    mem_hold_req_i = ($urandom_range(0, 9) < 2);
    jump_req_i     = ($urandom_range(0, 9) < 2);
    jump_addr_i    = $urandom;
    int_addr_i     = $urandom;
  endtask

  // One clock: model consumes the same inputs the DUT samples, then compare.
  task automatic cycle();
    logic [37:0] e;
    @(posedge clk);
    model_step();
    #1;
    e = exp_q.pop_front();
    check("hold", 32'(hold_flag_o), 32'(e[37:35]));
    check("jump", 32'(jump_o), 32'(e[34]));
    check("addr", jump_addr_o, e[33:2]);
    check("ack",  32'(int_ack_o), 32'(e[1]));
    check("wdt",  32'(wdt_timeout_o), 32'(e[0]));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    check_zero("rst_async");
    model_reset();
    repeat (n) begin
      @(posedge clk);
      #1;
      rand_drive();
      int_req_i = $urandom_range(0, 1);
      check_zero("rst_hold");
    end
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen;
    logic exp_pulse;
    model_reset();

    // reset held with random inputs
    repeat (5) begin
      @(negedge clk);
      rand_drive();
      int_req_i = $urandom_range(0, 1);
      #1;
      check_zero("reset");
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 32'd0, 0, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("idle_hold", 32'(hold_flag_o), 32'd0);
    end

    // stall priority
    drive(1, 1, 1, 0, 32'd0, 0, 32'd0);
    cycle(); check("lvl_mem", 32'(hold_flag_o), 32'd5);
    drive(1, 1, 0, 0, 32'd0, 0, 32'd0);
    cycle(); check("lvl_ex", 32'(hold_flag_o), 32'd4);
    drive(1, 0, 0, 0, 32'd0, 0, 32'd0);
    cycle(); check("lvl_id", 32'(hold_flag_o), 32'd3);
    drive(0, 0, 0, 0, 32'd0, 0, 32'd0);
    cycle();

    // simple jump
    drive(0, 0, 0, 1, 32'h8000_0040, 0, 32'd0);
    cycle();
    check("jmp_strobe", 32'(jump_o), 32'd1);
    check("jmp_addr", jump_addr_o, 32'h8000_0040);
    drive(0, 0, 0, 0, 32'd0, 0, 32'd0);
    cycle(); check("jmp_fl1", 32'(hold_flag_o), 32'd3); check("jmp_pulse", 32'(jump_o), 32'd0);
    cycle(); check("jmp_fl2", 32'(hold_flag_o), 32'd3);
    cycle(); check("jmp_done", 32'(hold_flag_o), 32'd0);
    check("jmp_addr_kept", jump_addr_o, 32'h8000_0040);

    // interrupt behind a MEM stall
    drive(0, 0, 1, 0, 32'd0, 1, 32'h0000_0100);
    for (int i = 0; i < 3; i++) begin
      cycle(); check("int_mem_hold", 32'(hold_flag_o), 32'd5);
    end
    drive(0, 0, 0, 0, 32'd0, 1, 32'h0000_0100);
    cycle();
    check("int_ack", 32'(int_ack_o), 32'd1);
    check("int_jump", 32'(jump_o), 32'd1);
    check("int_addr", jump_addr_o, 32'h0000_0100);
    drive(0, 0, 0, 0, 32'd0, 0, 32'd0);
    cycle(); check("int_fl1", 32'(hold_flag_o), 32'd3); check("int_ack_pulse", 32'(int_ack_o), 32'd0);
    cycle(); check("int_fl2", 32'(hold_flag_o), 32'd3);
    cycle(); check("int_done", 32'(hold_flag_o), 32'd0);

    // jump and interrupt together: jump first, interrupt afterwards
    drive(0, 0, 0, 1, 32'h8000_0200, 1, 32'h0000_0100);
    cycle();
    check("ji_jump", 32'(jump_o), 32'd1);
    check("ji_noack", 32'(int_ack_o), 32'd0);
    check("ji_addr", jump_addr_o, 32'h8000_0200);
    drive(0, 0, 0, 0, 32'd0, 1, 32'h0000_0100);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (int_ack_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("ji_int_taken", 32'(seen), 32'd1);
    check("ji_int_addr", jump_addr_o, 32'h0000_0100);
    drive(0, 0, 0, 0, 32'd0, 0, 32'd0);
    repeat (4) cycle();

    // long MEM stall: watchdog
    drive(0, 0, 1, 0, 32'd0, 0, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      cycle();
`ifdef PIPE_HOLD_WDT_EN
      exp_pulse = (k == 8 || k == 16);
`else
      exp_pulse = 1'b0;
`endif
      check("wdt_pulse", 32'(wdt_timeout_o), 32'(exp_pulse));
      check("wdt_hold", 32'(hold_flag_o), exp_pulse ? 32'd0 : 32'd5);
    end
    drive(0, 0, 0, 0, 32'd0, 0, 32'd0);
    repeat (3) cycle();

    // mid-operation reset: start a flush then reset
    drive(0, 0, 0, 1, 32'hDEAD_0000, 1, 32'h0000_0300);
    cycle();
    #2;
    do_reset(2);
    drive(0, 0, 0, 0, 32'd0, 0, 32'd0);
    cycle();
    check("post_rst_hold", 32'(hold_flag_o), 32'd0);

    // random traffic with sticky interrupt level and occasional reset
    for (int i = 0; i < 2000; i++) begin
      rand_drive();
      if (m_ack) int_req_i = 1'b0;
      else if ($urandom_range(0, 19) == 0) int_req_i = ~int_req_i;
      if ($urandom_range(0, 7) == 0) mem_hold_req_i = 1'b1;
      cycle();
      if ($urandom_range(0, 199) == 0) begin
        #2;
        do_reset($urandom_range(1, 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
